comparator_seq: RTL and testbench
=================================

// Module: comparator_seq
// PURPOSE
//  Multi-cycle magnitude comparator controller. It compares two WIDTH-bit operands using one shared
//  SLICE-bit compare slice, one slice per clock, and cascades the partial result. The slice cascade
//  semantics are identical to comparator_4b. This trades latency for area in wide-operand compare paths.
//  Valid/ready handshake on both the input and output sides.
// PARAMETERS
//  WIDTH  16  operand width; WIDTH % SLICE != 0 -> elaboration error
//  SLICE  4   bits compared per cycle; NSLICE = WIDTH/SLICE
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands (=1 only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result valid (=1 only in DONE)
//  out_ready  in   1      consumer takes result
//  l          out  1      a > b
//  g          out  1      a == b
//  m          out  1      a < b
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, l=g=m=0, slice counter=0, busy=0, in_ready=1.
//  - A reset mid-operation aborts the operation: no result is produced and the captured operands are discarded.
//  - FSM IDLE->RUN->DONE->IDLE. in_ready/out_valid/busy decode state (no comb path from inputs).
//  - IDLE: on in_valid&in_ready, register a,b into internal copies; later changes on a/b are ignored.
//    Init cascade l=0,g=1,m=0 (empty compare = equal); cnt=0; go RUN.
//  - RUN: each edge processes slice cnt and updates the cascade. For slice result (sl,seq,sm):
//    l' = sl | seq&l; g' = seq&g; m' = ~l'&~g'. Exactly one of l/g/m =1 after each step. cnt++.
//    After slice NSLICE-1, go DONE.
//  - Slice order without the macro: LSB first (slice 0 = bits [SLICE-1:0]), mirroring the chained-slice cascade.
//  - DONE: out_valid=1 and l/g/m are held stable until out_ready. out_valid&out_ready -> IDLE next edge.
//    in_valid is ignored while not in IDLE. Throughput: one operation per NSLICE+2 cycles minimum.
//  - Latency: out_valid rises NSLICE edges after the accepting edge.
//  - l/g/m are registered. They are meaningful only while out_valid=1; while not valid they hold the last value (0 after reset).
//  - cnt width = max(1,$clog2(NSLICE)); cnt does not wrap (RUN exits at NSLICE-1).
//  - NSLICE=1: single RUN cycle; result is a plain compare.
// CONFIGURATION
//  COMPARATOR_SEQ_EARLY_EXIT_EN
//   defined: slices are scanned MSB first. The cascade is replaced by first-difference detection: the first
//    unequal slice sets l or m and the FSM goes DONE on that same edge. If all slices are equal, g=1 after
//    NSLICE edges. Latency = 1-based index (from MSB) of the first differing slice, max NSLICE.
//   undefined: fixed-latency LSB-first cascade as described above. Results are identical in both modes;
//    only the latency differs.
// TESTING (WIDTH=16, SLICE=4)
//  1 rst high 2 cycles -> in_ready=1, out_valid=0, busy=0, l=g=m=0.
//  2 a=16'h1234,b=16'h1234 -> out_valid 4 edges after accept, g=1,l=0,m=0 (both modes).
//  3 a=16'h8000,b=16'h7FFF -> l=1,g=0,m=0. Latency 4 edges; with EARLY_EXIT_EN, 1 edge.
//  4 a=16'h0001,b=16'h0002 -> m=1. Latency 4 edges in both modes. Also change a/b during RUN -> result unchanged.
//  5 out_ready=0 for 10 cycles in DONE, with in_valid pulsed -> out_valid and l/g/m stable, in_ready=0,
//    no capture. Then out_ready=1 -> IDLE next edge, in_ready=1.
//  6 rst on 2nd RUN cycle -> IDLE next edge, out_valid never rises. Then a=16'h0005,b=16'h0003 -> l=1.

Source files
------------

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle magnitude comparator, one SLICE-bit slice per clock.
// Optional macro COMPARATOR_SEQ_EARLY_EXIT_EN: MSB-first scan that finishes on the first differing slice.
module comparator_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             l,
  output logic             g,
  output logic             m,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("comparator_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic            cl_q, cl_d, cg_q, cg_d, cm_q, cm_d;
  logic            l_q, l_d, g_q, g_d, m_q, m_d;

  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SLICE-1:0] sa, sb;
  logic             sl, seq;
  logic             nl, ng, nm;
  logic             finish;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  assign idx = LAST - cnt_q;
`else
  assign idx = cnt_q;
`endif

  assign a_sh = a_q >> (idx * SLICE);
  assign b_sh = b_q >> (idx * SLICE);
  assign sa   = a_sh[SLICE-1:0];
  assign sb   = b_sh[SLICE-1:0];
  assign sl   = (sa > sb);
  assign seq  = (sa == sb);

  always_comb begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    // First unequal slice from the top decides; equal slices leave the "equal" state intact.
    nl     = ~seq & sl;
    ng     = seq & cg_q;
    nm     = ~seq & ~sl;
    finish = ~seq | (cnt_q == LAST);
`else
    nl     = sl | (seq & cl_q);
    ng     = seq & cg_q;
    nm     = ~nl & ~ng;
    finish = (cnt_q == LAST);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cl_d    = cl_q;
    cg_d    = cg_q;
    cm_d    = cm_q;
    l_d     = l_q;
    g_d     = g_q;
    m_d     = m_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cl_d    = 1'b0;
          cg_d    = 1'b1;
          cm_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cl_d = nl;
        cg_d = ng;
        cm_d = nm;
        if (finish) begin
          // Outputs only change when a result is published, so they hold otherwise.
          l_d     = nl;
          g_d     = ng;
          m_d     = nm;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cl_q    <= 1'b0;
      cg_q    <= 1'b0;
      cm_q    <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cl_q    <= cl_d;
      cg_q    <= cg_d;
      cm_q    <= cm_d;
      l_q     <= l_d;
      g_q     <= g_d;
      m_q     <= m_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign l         = l_q;
  assign g         = g_q;
  assign m         = m_q;

endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - directed self-checking bench for comparator_seq (WIDTH=16, SLICE=4).
module tb_comparator_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        l, g, m, busy;

  int compared = 0;
  int mismatched = 0;
  int lat;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam int LAT3 = 1;
`else
  localparam int LAT3 = 4;
`endif

  comparator_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .l(l), .g(g), .m(m), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then count edges until out_valid.
  task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv, output int n);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_lgm", {29'b0, l, g, m}, 32'b000);

    // 2: equal operands
    start_and_wait(16'h1234, 16'h1234, lat);
    check("eq_latency", lat, 32'd4);
    check("eq_lgm", {29'b0, l, g, m}, 32'b010);
    release_result("eq");
    check("eq_hold_lgm", {29'b0, l, g, m}, 32'b010);

    // 3: a > b decided in the top slice
    start_and_wait(16'h8000, 16'h7FFF, lat);
    check("gt_latency", lat, LAT3);
    check("gt_lgm", {29'b0, l, g, m}, 32'b100);
    release_result("gt");

    // 4: a < b, operands disturbed while running
    a = 16'h0001;
    b = 16'h0002;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lt_busy", {31'b0, busy}, 32'd1);
    check("lt_in_ready", {31'b0, in_ready}, 32'd0);
    a = 16'hFFFF;
    b = 16'h0000;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("lt_latency", lat, 32'd4);
    check("lt_lgm", {29'b0, l, g, m}, 32'b001);
    release_result("lt");

    // 5: backpressure in DONE with in_valid pulsing
    start_and_wait(16'hABCD, 16'hABCC, lat);
    check("bp_latency", lat, LAT3 == 1 ? 32'd4 : 32'd4);
    for (int i = 0; i < 10; i++) begin
      a = 16'h0000;
      b = 16'hFFFF;
      in_valid = i[0];
      step();
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_lgm", {29'b0, l, g, m}, 32'b100);
    end
    in_valid = 1'b0;
    release_result("bp");
    step();
    check("bp_no_capture", {31'b0, busy}, 32'd0);

    // 6: reset on the second RUN cycle aborts
    a = 16'h00FF;
    b = 16'h0F00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end
    start_and_wait(16'h0005, 16'h0003, lat);
    check("post_latency", lat, 32'd4);
    check("post_lgm", {29'b0, l, g, m}, 32'b100);
    release_result("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
